// File: rtl/display_scheduler.sv
// Display sequencer for the DDR game's four-digit seven-segment path: picks the frame
// per game state, converts score/combo to decimal, and scans one digit per refresh slot.
module display_scheduler #(
    parameter int REFRESH_DIV = 50000,
    parameter int ALT_DIV     = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  state,
    input  logic [1:0]  arrow,
    input  logic        arrow_valid,
    input  logic [13:0] score,
    input  logic [13:0] combo_count,
    input  logic        combo_enable,
    output logic [3:0]  an,
    output logic [3:0]  digit_code,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GAME  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    localparam logic [1:0] BCD_IDLE  = 2'd0;
    localparam logic [1:0] BCD_LOAD  = 2'd1;
    localparam logic [1:0] BCD_SHIFT = 2'd2;
    localparam logic [1:0] BCD_DONE  = 2'd3;

    localparam logic [3:0]  BLANK       = 4'd10;
    localparam logic [15:0] BLANK_FRAME = {4{BLANK}};
    localparam int          RW          = $clog2(REFRESH_DIV);
    localparam int          AW          = $clog2(ALT_DIV);

    logic [1:0]    game_st;
    logic [1:0]    prev_st;
    logic [RW-1:0] ref_cnt;
    logic          ref_tick;
    logic [1:0]    slot;
    logic [1:0]    next_slot;
    logic [15:0]   frame;
    logic [3:0]    next_digit;

    logic [15:0]   arr_buf;
    logic [3:0]    arrow_code;
    logic          game_from_idle;

    logic          combo_en_q;
    logic          pause_entry;
    logic          alt_restart;
    logic          alt_phase;
    logic [AW-1:0] alt_cnt;
    logic          alt_tick;
    logic          use_combo;
    logic [13:0]   src_val;
    logic [13:0]   src_sat;

    logic [1:0]    bcd_st;
    logic [3:0]    bit_cnt;
    logic [13:0]   bin_sr;
    logic [15:0]   bcd_sr;
    logic [15:0]   bcd_adj;
    logic [15:0]   num_next;
    logic [15:0]   num_buf;
    logic [13:0]   conv_val;
    logic          conv_sel;
    logic [13:0]   last_val;
    logic          last_sel;
    logic          last_valid;
    logic          need_conv;

    assign game_st        = (state == 2'b11) ? ST_IDLE : state;
    assign game_from_idle = (game_st == ST_GAME) && (prev_st == ST_IDLE);
    assign pause_entry    = (game_st == ST_PAUSE) && (prev_st != ST_PAUSE);
    assign arrow_code     = 4'd11 + {2'b00, arrow};

    // ---------------- refresh scan ----------------
    assign ref_tick  = (ref_cnt == RW'(REFRESH_DIV - 1));
    assign next_slot = slot + 2'd1;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        frame = BLANK_FRAME;
        case (game_st)
            ST_GAME:  frame = arr_buf;
            ST_PAUSE: frame = num_buf;
            default:  frame = BLANK_FRAME;
        endcase
        next_digit = BLANK;
        case (next_slot)
            2'd0: next_digit = frame[15:12];
            2'd1: next_digit = frame[11:8];
            2'd2: next_digit = frame[7:4];
            2'd3: next_digit = frame[3:0];
            default: next_digit = BLANK;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt    <= '0;
            slot       <= 2'd0;
            an         <= 4'b0111;
            digit_code <= BLANK;
            prev_st    <= ST_IDLE;
        end else begin
            prev_st <= game_st;
            if (ref_tick) begin
                ref_cnt    <= '0;
                slot       <= next_slot;
                an         <= ~(4'b1000 >> next_slot);
                digit_code <= next_digit;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
        end
    end

    // ---------------- arrow history ----------------
    // Entering GAME from IDLE clears first; a same-cycle arrow lands in the cleared buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_buf <= BLANK_FRAME;
        end else if (game_from_idle) begin
            arr_buf <= arrow_valid ? {BLANK_FRAME[11:0], arrow_code} : BLANK_FRAME;
        end else if (arrow_valid && game_st == ST_GAME) begin
            arr_buf <= {arr_buf[11:0], arrow_code};
        end
    end

    // ---------------- combo/score alternation ----------------
    assign alt_restart = (combo_enable && !combo_en_q) || pause_entry;
    assign alt_tick    = (alt_cnt == AW'(ALT_DIV - 1));
    // A restart cycle already counts as combo phase so the source never glitches to score.
    assign use_combo   = combo_enable && (alt_restart || !alt_phase);
    assign src_val     = use_combo ? combo_count : score;
    assign src_sat     = (src_val > 14'd9999) ? 14'd9999 : src_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            combo_en_q <= 1'b0;
            alt_cnt    <= '0;
            alt_phase  <= 1'b0;
        end else begin
            combo_en_q <= combo_enable;
            if (alt_restart) begin
                alt_cnt   <= '0;
                alt_phase <= 1'b0;
            end else if (alt_tick) begin
                alt_cnt   <= '0;
                alt_phase <= ~alt_phase;
            end else begin
                alt_cnt <= alt_cnt + AW'(1);
            end
        end
    end

    // ---------------- double-dabble BCD engine ----------------
    assign need_conv = (game_st == ST_PAUSE) &&
                       (!last_valid || src_val != last_val || use_combo != last_sel);
    assign busy      = (bcd_st != BCD_IDLE);

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // Leading zeros blank left to right; the units digit always shows.
    always_comb begin
        logic b0, b1, b2;
        b0 = (bcd_sr[15:12] == 4'd0);
        b1 = b0 && (bcd_sr[11:8] == 4'd0);
        b2 = b1 && (bcd_sr[7:4] == 4'd0);
        num_next = {b0 ? BLANK : bcd_sr[15:12],
                    b1 ? BLANK : bcd_sr[11:8],
                    b2 ? BLANK : bcd_sr[7:4],
                    bcd_sr[3:0]};
    end

    // NOTE: the digit buffers are plain registers and take the async reset; a reset mid-conversion discards the partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_st     <= BCD_IDLE;
            bit_cnt    <= 4'd0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            conv_val   <= '0;
            conv_sel   <= 1'b0;
            last_val   <= '0;
            last_sel   <= 1'b0;
            last_valid <= 1'b0;
            num_buf    <= BLANK_FRAME;
        end else begin
            case (bcd_st)
                BCD_IDLE: begin
                    if (need_conv) bcd_st <= BCD_LOAD;
                end
                BCD_LOAD: begin
                    conv_val <= src_val;
                    conv_sel <= use_combo;
                    bin_sr   <= src_sat;
                    bcd_sr   <= '0;
                    bit_cnt  <= 4'd0;
                    bcd_st   <= BCD_SHIFT;
                end
                BCD_SHIFT: begin
                    bcd_sr  <= {bcd_adj[14:0], bin_sr[13]};
                    bin_sr  <= {bin_sr[12:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd13) bcd_st <= BCD_DONE;
                end
                BCD_DONE: begin
                    num_buf    <= num_next;
                    last_val   <= conv_val;
                    last_sel   <= conv_sel;
                    last_valid <= 1'b1;
                    bcd_st     <= BCD_IDLE;
                end
                default: bcd_st <= BCD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: expected frames are queued per scenario and
// popped as the scan presents each digit slot.
module tb_display_scheduler;

    localparam int         REFRESH_DIV = 4;
    localparam int         ALT_DIV     = 100;
    localparam logic [3:0] B           = 4'd10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  state = 2'b00;
    logic [1:0]  arrow = 2'd0;
    logic        arrow_valid = 1'b0;
    logic [13:0] score = '0;
    logic [13:0] combo_count = '0;
    logic        combo_enable = 1'b0;
    logic [3:0]  an;
    logic [3:0]  digit_code;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [3:0]  exp_q[$];

    display_scheduler #(.REFRESH_DIV(REFRESH_DIV), .ALT_DIV(ALT_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .arrow(arrow), .arrow_valid(arrow_valid),
        .score(score), .combo_count(combo_count), .combo_enable(combo_enable),
        .an(an), .digit_code(digit_code), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [15:0] f);
        exp_q.push_back(f[15:12]);
        exp_q.push_back(f[11:8]);
        exp_q.push_back(f[7:4]);
        exp_q.push_back(f[3:0]);
    endtask

    // Scoreboard consumer: collect the next four scanned slots and compare against the queue.
    task automatic sb_frame(input string name);
        logic [3:0] got[4];
        logic [3:0] prev_an;
        logic [3:0] exp_d;
        int n, guard, s;
        for (int i = 0; i < 4; i++) got[i] = 4'hF;
        prev_an = an;
        n = 0;
        guard = 0;
        while (n < 4 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (an !== prev_an) begin
                prev_an = an;
                case (an)
                    4'b0111: s = 0;
                    4'b1011: s = 1;
                    4'b1101: s = 2;
                    4'b1110: s = 3;
                    default: s = -1;
                endcase
                if (s >= 0) got[s] = digit_code;
                n++;
            end
        end
        total++;
        if (n < 4) begin
            bad++;
            $display("FAIL %s_scan: saw %0d slot changes, expected 4", name, n);
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = exp_q.pop_front();
            total++;
            if (got[i] !== exp_d) begin
                bad++;
                $display("FAIL %s slot%0d: got %0d expected %0d", name, i, got[i], exp_d);
            end
        end
    endtask

    task automatic wait_busy(input logic level, input int bound, output int n);
        n = 0;
        while (busy !== level && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy !== level) n = -1;
    endtask

    task automatic pulse_arrow(input logic [1:0] a);
        @(negedge clk);
        arrow = a;
        arrow_valid = 1'b1;
        @(negedge clk);
        arrow_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] seq[4] = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};
        logic [3:0] cur;
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (an !== 4'b0111) begin bad++; $display("FAIL reset_an: got %b expected 0111", an); end
        total++; if (digit_code !== B) begin bad++; $display("FAIL reset_digit: got %0d expected 10", digit_code); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        n = 0;
        while (an === 4'b0111 && n < 8) begin @(negedge clk); n++; end
        total++; if (an !== 4'b1011) begin bad++; $display("FAIL first_tick_an: got %b expected 1011", an); end
        cur = an;
        for (int k = 0; k < 4; k++) begin
            repeat (3) @(negedge clk);
            total++; if (an !== cur) begin bad++; $display("FAIL an_hold%0d: got %b expected %b", k, an, cur); end
            @(negedge clk);
            total++; if (an !== seq[k]) begin bad++; $display("FAIL an_step%0d: got %b expected %b", k, an, seq[k]); end
            cur = seq[k];
        end
        push_frame({4{B}});
        sb_frame("idle_blank");
    endtask

    task automatic test_game();
        @(negedge clk);
        state = 2'b01;
        pulse_arrow(2'd0); pulse_arrow(2'd1); pulse_arrow(2'd2); pulse_arrow(2'd3); pulse_arrow(2'd2);
        push_frame({4'd12, 4'd13, 4'd14, 4'd13});
        sb_frame("game_arrows");
        // PAUSE ignores arrows and returning to GAME keeps the history.
        @(negedge clk); state = 2'b10;
        pulse_arrow(2'd0);
        @(negedge clk); state = 2'b01;
        push_frame({4'd12, 4'd13, 4'd14, 4'd13});
        sb_frame("pause_keeps");
        @(negedge clk); state = 2'b00;
        pulse_arrow(2'd1);
        push_frame({4{B}});
        sb_frame("idle_frame");
        @(negedge clk); state = 2'b01;
        push_frame({4{B}});
        sb_frame("game_cleared");
        @(negedge clk); state = 2'b11;
        @(negedge clk);
        state = 2'b01; arrow = 2'd3; arrow_valid = 1'b1;
        @(negedge clk); arrow_valid = 1'b0;
        push_frame({B, B, B, 4'd14});
        sb_frame("game_same_cycle");
    endtask

    task automatic test_bcd();
        logic [13:0] vals[3] = '{14'd7, 14'd12000, 14'd0};
        logic [15:0] frames[3] = '{{B, B, B, 4'd7}, 16'h9999, {B, B, B, 4'd0}};
        int n, hi;
        wait_busy(1'b0, 40, n);
        @(negedge clk);
        state = 2'b10; combo_enable = 1'b0; score = 14'd1234;
        wait_busy(1'b1, 4, n);
        total++; if (n < 0) begin bad++; $display("FAIL bcd_start: busy never rose"); end
        hi = 0;
        while (busy === 1'b1 && hi < 40) begin hi++; @(negedge clk); end
        total++; if (hi != 16) begin bad++; $display("FAIL busy_len: got %0d expected 16", hi); end
        push_frame({4'd1, 4'd2, 4'd3, 4'd4});
        sb_frame("score_1234");
        for (int i = 0; i < 3; i++) begin
            score = vals[i];
            wait_busy(1'b1, 4, n);
            total++; if (n < 0) begin bad++; $display("FAIL conv_start%0d: busy never rose", i); end
            wait_busy(1'b0, 20, n);
            push_frame(frames[i]);
            sb_frame($sformatf("score_%0d", vals[i]));
        end
    endtask

    task automatic test_combo();
        logic [15:0] f42  = {B, B, 4'd4, 4'd2};
        logic [15:0] f305 = {B, 4'd3, 4'd0, 4'd5};
        int n, t0, t1, t2;
        score = 14'd305; combo_count = 14'd42;
        wait_busy(1'b1, 4, n);
        wait_busy(1'b0, 20, n);
        @(negedge clk);
        combo_enable = 1'b1; t0 = cyc;
        wait_busy(1'b1, 4, n);
        total++; if (n < 0) begin bad++; $display("FAIL combo_start: busy never rose"); end
        wait_busy(1'b0, 20, n);
        push_frame(f42);
        sb_frame("combo_42");
        wait_busy(1'b1, 150, n); t1 = cyc;
        total++; if (t1 - t0 < 100 || t1 - t0 > 104) begin bad++; $display("FAIL combo_phase_len: got %0d expected 100..104", t1 - t0); end
        wait_busy(1'b0, 20, n);
        push_frame(f305);
        sb_frame("combo_305");
        wait_busy(1'b1, 150, n); t2 = cyc;
        total++; if (t2 - t1 != ALT_DIV) begin bad++; $display("FAIL score_phase_len: got %0d expected %0d", t2 - t1, ALT_DIV); end
        wait_busy(1'b0, 20, n);
        push_frame(f42);
        sb_frame("combo_back");
        // Re-enable during a score phase must restart on combo immediately.
        wait_busy(1'b1, 150, n);
        wait_busy(1'b0, 20, n);
        combo_enable = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL combo_off_idle: got busy=%b expected 0", busy); end
        combo_enable = 1'b1; t0 = cyc;
        wait_busy(1'b1, 3, n);
        total++; if (n < 0) begin bad++; $display("FAIL combo_restart: busy did not rise within 3 cycles"); end
        wait_busy(1'b0, 20, n);
        push_frame(f42);
        sb_frame("combo_restart");
        wait_busy(1'b1, 150, n); t1 = cyc;
        total++; if (t1 - t0 < 100 || t1 - t0 > 104) begin bad++; $display("FAIL restart_phase_len: got %0d expected 100..104", t1 - t0); end
        wait_busy(1'b0, 20, n);
    endtask

    task automatic test_mid_change();
        int n, lo, quiet, guard;
        combo_enable = 1'b0; score = 14'd9;
        quiet = 0; guard = 0;
        while (quiet < 3 && guard < 200) begin
            @(negedge clk); guard++;
            if (busy === 1'b1) quiet = 0; else quiet++;
        end
        total++; if (quiet < 3) begin bad++; $display("FAIL mid_settle: busy never settled"); end
        score = 14'd1234;
        wait_busy(1'b1, 4, n);
        repeat (5) @(negedge clk);
        score = 14'd5678;
        wait_busy(1'b0, 20, n);
        total++; if (n < 0) begin bad++; $display("FAIL mid_done: first conversion never finished"); end
        lo = 0;
        while (busy === 1'b0 && lo < 5) begin lo++; @(negedge clk); end
        total++; if (lo != 1) begin bad++; $display("FAIL mid_gap: got %0d idle cycles expected 1", lo); end
        push_frame({4'd1, 4'd2, 4'd3, 4'd4});
        sb_frame("mid_first");
        wait_busy(1'b0, 20, n);
        push_frame({4'd5, 4'd6, 4'd7, 4'd8});
        sb_frame("mid_second");
    endtask

    task automatic test_reset_mid();
        int n;
        score = 14'd4321;
        wait_busy(1'b1, 4, n);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        total++; if (an !== 4'b0111) begin bad++; $display("FAIL rst_mid_an: got %b expected 0111", an); end
        total++; if (digit_code !== B) begin bad++; $display("FAIL rst_mid_digit: got %0d expected 10", digit_code); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_busy(1'b1, 4, n);
        total++; if (n < 0) begin bad++; $display("FAIL rst_reconvert: busy never rose"); end
        wait_busy(1'b0, 20, n);
        push_frame({4'd4, 4'd3, 4'd2, 4'd1});
        sb_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_game();
        test_bcd();
        test_combo();
        test_mid_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
